// File: rtl/fifo_rr_drain_pkg.sv
// Shared constants and helpers for the round-robin drain arbiter family.
package fifo_rr_drain_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
  import fifo_rr_drain_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  any,
  output logic [clog2(N)-1:0]   idx
);

  localparam int SW = clog2(N);

  int k;

  // Explicit wrap compare keeps non-power-of-two N correct.
  always_comb begin
    any = FALSE;
    idx = '0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any = TRUE;
        idx = SW'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N FWFT source FIFOs into one downstream write port,
// in bursts of up to BURST words, honouring downstream stall.
module fifo_rr_drain
  import fifo_rr_drain_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 8,
  parameter int DELAY = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N-1:0]          empty,
  input  logic [N*WIDTH-1:0]    din,
  output logic [N-1:0]          rden,
  input  logic                  stall,
  output logic                  wren,
  output logic [WIDTH-1:0]      dout,
  output logic [clog2(N)-1:0]   src,
  output logic                  busy
);

  localparam int SW = clog2(N);
  localparam int CW = clog2(BURST + 1);

  // DELAY only shaped simulation timing in the legacy block; it is range-checked here.
  if (N < 2 || BURST < 1 || DELAY < 0) begin : g_param_check
    $error("fifo_rr_drain: requires N >= 2, BURST >= 1, DELAY >= 0");
  end

  logic [0:0]    state;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [CW-1:0] count;
  logic          any;
  logic [SW-1:0] idx;
  logic          pop_p0;
  logic          last_p0;
  logic          end_p0;

  rr_pick #(.N(N)) u_pick (
    .req (~empty),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  assign pop_p0  = (state == XFER) && !empty[g] && !stall;
  assign last_p0 = pop_p0 && (count == CW'(BURST - 1));
  assign end_p0  = (state == XFER) && (last_p0 || empty[g]);
  assign busy    = (state == XFER);

  always_comb begin
    rden    = '0;
    rden[g] = pop_p0;
  end

  // Stage boundary: popped word becomes the registered downstream write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      count <= '0;
      wren  <= FALSE;
      dout  <= '0;
      src   <= '0;
    end else if (state == IDLE) begin
      wren <= FALSE;
      if (any) begin
        g     <= idx;
        count <= '0;
        state <= XFER;
      end
    end else begin
      wren <= pop_p0;
      if (pop_p0) begin
        dout  <= din[int'(g)*WIDTH +: WIDTH];
        src   <= g;
        count <= count + 1'b1;
      end
      if (end_p0) begin
        ptr   <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Scoreboard bench for fifo_rr_drain with behavioural FWFT sources.
module tb_fifo_rr_drain;

  localparam int N = 4;
  localparam int W = 32;
  localparam int B = 8;

  logic           CLK = 1'b0;
  logic           RESET = 1'b0;
  logic [N-1:0]   empty = '1;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   rden;
  logic           stall = 1'b0;
  logic           wren;
  logic [W-1:0]   dout;
  logic [1:0]     src;
  logic           busy;

  always #5 CLK = ~CLK;

  fifo_rr_drain #(.N(N), .WIDTH(W), .BURST(B), .DELAY(1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .empty (empty),
    .din   (din),
    .rden  (rden),
    .stall (stall),
    .wren  (wren),
    .dout  (dout),
    .src   (src),
    .busy  (busy)
  );

  typedef struct packed {
    logic [1:0]   s;
    logic [W-1:0] d;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mem [N][64];
  int           head [N];
  int           tail [N];
  int           total = 0;
  int           bad = 0;
  int           nwr = 0;
  int           npop = 0;
  bit           pend_vld = 0;
  int           pend_k = 0;
  bit           wr_trace[$];
  int           src_trace[$];
  int           runs_len[$];
  int           runs_src[$];
  int           gaps[$];
  int           first_wr;
  int           last_wr;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      mem[k][tail[k]] = (k + 1) * 32'h1000 + tail[k];
      tail[k]++;
    end
  endtask

  task automatic step(input bit st);
    exp_t e;
    @(negedge CLK);
    if (pend_vld) begin
      head[pend_k]++;
      npop++;
    end
    pend_vld = 0;
    wr_trace.push_back(wren);
    src_trace.push_back(int'(src));
    if (wren) begin
      nwr++;
      if (exp_q.size() == 0) chk_eq("spurious_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk_eq("wr_data", dout, e.d);
        chk_eq("wr_src", src, e.s);
      end
    end
    stall = st;
    for (int k = 0; k < N; k++) begin
      empty[k] = (head[k] == tail[k]);
      din[k*W +: W] = mem[k][head[k]];
    end
    #1;
    if (rden != '0) begin
      chk_eq("rden_onehot", $countones(rden), 1);
      for (int k = 0; k < N; k++) begin
        if (rden[k]) begin
          chk_eq("rden_legal", {empty[k], stall}, 0);
          pend_vld = 1;
          pend_k = k;
          e.s = 2'(k);
          e.d = mem[k][head[k]];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic clear_trace();
    nwr = 0;
    npop = 0;
    wr_trace.delete();
    src_trace.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    chk_eq("rst_wren", wren, 0);
    chk_eq("rst_rden", rden, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_src", src, 0);
    chk_eq("rst_dout", dout, 0);
    pend_vld = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    step(0);
    step(0);
    RESET = 1'b0;
    clear_trace();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (nwr < n && c < budget) begin
      step(0);
      c++;
    end
    chk_eq("writes_in_budget", nwr, n);
    repeat (3) step(0);
    chk_eq("no_extra_writes", nwr, n);
  endtask

  task automatic analyze();
    int cur;
    int z;
    bit started;
    cur = 0;
    z = 0;
    started = 0;
    first_wr = -1;
    last_wr = -1;
    runs_len.delete();
    runs_src.delete();
    gaps.delete();
    foreach (wr_trace[i]) begin
      if (wr_trace[i]) begin
        if (first_wr < 0) first_wr = i;
        last_wr = i;
        if (cur == 0) begin
          runs_src.push_back(src_trace[i]);
          if (started) gaps.push_back(z);
        end
        cur++;
        started = 1;
        z = 0;
      end else begin
        if (cur > 0) runs_len.push_back(cur);
        cur = 0;
        if (started) z++;
      end
    end
    if (cur > 0) runs_len.push_back(cur);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    do_reset();

    // Single source, 20 words: bursts 8, 8, 4 with one idle cycle between.
    load(2, 20);
    run_until(20, 80);
    analyze();
    chk_eq("t1_runs", runs_len.size(), 3);
    if (runs_len.size() == 3) begin
      chk_eq("t1_len0", runs_len[0], 8);
      chk_eq("t1_len1", runs_len[1], 8);
      chk_eq("t1_len2", runs_len[2], 4);
      chk_eq("t1_gap0", gaps[0], 1);
      chk_eq("t1_gap1", gaps[1], 1);
      foreach (runs_src[i]) chk_eq("t1_src", runs_src[i], 2);
    end

    // All four sources loaded: grants 0,1,2,3, 8 words each, 35-cycle span.
    do_reset();
    for (int k = 0; k < N; k++) load(k, 8);
    run_until(32, 120);
    analyze();
    chk_eq("t2_runs", runs_len.size(), 4);
    if (runs_len.size() == 4) begin
      foreach (runs_len[i]) chk_eq("t2_len", runs_len[i], 8);
      foreach (runs_src[i]) chk_eq("t2_order", runs_src[i], i);
    end
    chk_eq("t2_span", last_wr - first_wr + 1, 35);

    // Source 1 runs dry after 3 words; next search starts at index 2.
    do_reset();
    load(1, 3);
    run_until(3, 20);
    analyze();
    chk_eq("t3_runs", runs_len.size(), 1);
    if (runs_len.size() == 1) begin
      chk_eq("t3_len", runs_len[0], 3);
      chk_eq("t3_src", runs_src[0], 1);
    end
    chk_eq("t3_idle", busy, 0);
    clear_trace();
    load(0, 2);
    load(3, 2);
    run_until(4, 30);
    analyze();
    chk_eq("t3_next_runs", runs_src.size(), 2);
    if (runs_src.size() == 2) begin
      chk_eq("t3_next0", runs_src[0], 3);
      chk_eq("t3_next1", runs_src[1], 0);
    end

    // Five-cycle stall after the 4th pop: grant held, no pops, no loss.
    do_reset();
    load(0, 8);
    for (int c = 0; c < 20 && (npop + int'(pend_vld)) < 4; c++) step(0);
    chk_eq("t4_four_pops", npop + int'(pend_vld), 4);
    for (int s = 0; s < 5; s++) begin
      step(1);
      chk_eq("t4_stall_rden", rden, 0);
      chk_eq("t4_stall_busy", busy, 1);
      if (s == 0) chk_eq("t4_inflight_wren", wren, 1);
      else chk_eq("t4_stall_wren", wren, 0);
    end
    run_until(8, 40);
    analyze();
    chk_eq("t4_runs", runs_len.size(), 2);
    if (runs_len.size() == 2) begin
      chk_eq("t4_len0", runs_len[0], 4);
      chk_eq("t4_len1", runs_len[1], 4);
      chk_eq("t4_gap", gaps[0], 5);
    end
    chk_eq("t4_sb_empty", exp_q.size(), 0);

    // Wrap-around: burst on source 2 leaves ptr=3; then 3 before 0.
    do_reset();
    load(2, 1);
    run_until(1, 20);
    clear_trace();
    load(0, 2);
    load(3, 2);
    run_until(4, 30);
    analyze();
    chk_eq("t5_runs", runs_src.size(), 2);
    if (runs_src.size() == 2) begin
      chk_eq("t5_first", runs_src[0], 3);
      chk_eq("t5_second", runs_src[1], 0);
    end

    // Reset mid-burst clears outputs at once; next grant starts from 0.
    do_reset();
    load(1, 8);
    for (int c = 0; c < 20 && (npop + int'(pend_vld)) < 3; c++) step(0);
    chk_eq("t6_mid_busy", busy, 1);
    chk_eq("t6_mid_wren", wren, 1);
    do_reset();
    load(0, 2);
    load(1, 2);
    run_until(4, 30);
    analyze();
    chk_eq("t6_runs", runs_src.size(), 2);
    if (runs_src.size() == 2) begin
      chk_eq("t6_first", runs_src[0], 0);
      chk_eq("t6_second", runs_src[1], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
